// File: rtl/btn_frontend_pkg.sv
// Shared definitions for the push-button front end: channel indices,
// default sizing, repeat FSM states and a counter-width helper.
package btn_frontend_pkg;

  // Channel index order as wired at the game top level.
  localparam int BTN_UP    = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_DOWN  = 3;
  localparam int BTN_GUESS = 4;
  localparam int BTN_NEW   = 5;

  localparam int NUM_BTN_DEFAULT = BTN_NEW + 1;

  // Only the directional buttons auto-repeat by default.
  localparam logic [5:0] REPEAT_MASK_DEFAULT =
    6'((1 << BTN_UP) | (1 << BTN_LEFT) | (1 << BTN_RIGHT) | (1 << BTN_DOWN));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RPT  = 2'd2
  } rpt_state_t;

  // Counter width for a terminal count of v: $clog2(v), never below 1 bit.
  function automatic int clog2_min1(input int v);
    int w;
    w = $clog2(v);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_frontend_if.sv
// Pin-side bundle of the button front end: raw pins and logic-analyser
// override in, conditioned levels, press pulses and debug taps out.
interface btn_frontend_if
  import btn_frontend_pkg::*;
#(
  parameter int NUM_BTN = NUM_BTN_DEFAULT
);

  logic [NUM_BTN-1:0]   btn_raw;
  logic [NUM_BTN-1:0]   la_in;
  logic [NUM_BTN-1:0]   la_mask;
  logic [NUM_BTN-1:0]   btn_level;
  logic [NUM_BTN-1:0]   btn_press;
  logic [2*NUM_BTN-1:0] debug_out;

  modport master (
    output btn_raw, la_in, la_mask,
    input  btn_level, btn_press, debug_out
  );

  modport slave (
    input  btn_raw, la_in, la_mask,
    output btn_level, btn_press, debug_out
  );

endinterface

// File: rtl/btn_frontend_channel.sv
// One button channel: raw-pin synchroniser, logic-analyser override mux,
// debouncer, rising-edge detect and the optional auto-repeat FSM.
module btn_frontend_channel
  import btn_frontend_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int REPEAT_DELAY    = 1 << 22,
  parameter int REPEAT_RATE     = 1 << 20,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic la_in,
  input  logic la_mask,
  output logic sync,
  output logic level,
  output logic press_req
);

  localparam int DBW = clog2_min1(DEBOUNCE_CYCLES);
  localparam int RW_D = clog2_min1(REPEAT_DELAY);
  localparam int RW_R = clog2_min1(REPEAT_RATE);
  localparam int RW = (RW_D > RW_R) ? RW_D : RW_R;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]  RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]  RR_LAST = RW'(REPEAT_RATE - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic [DBW-1:0]         cnt_q;
  logic                   level_q;
  logic                   eff;
  logic                   rise;
  rpt_state_t             state_q, state_d;
  logic [RW-1:0]          rcnt_q, rcnt_d;
  logic                   rpt_pulse;

  // Shift the asynchronous pin through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (!rst) sync_p0 <= '0;
    else      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw};
  end

  assign sync = sync_p0[SYNC_STAGES-1];
  assign eff  = la_mask ? la_in : sync;

  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive
  // mismatching cycles; an overridden channel follows la_in directly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      level <= 1'b0;
    end else if (la_mask) begin
      cnt_q <= '0;
      level <= eff;
    end else if (eff != level) begin
      if (cnt_q == DB_LAST) begin
        cnt_q <= '0;
        level <= ~level;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  // Delayed copy of the level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst) level_q <= 1'b0;
    else      level_q <= level;
  end

  assign rise = level & ~level_q;

  // Repeat FSM state and timer register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Repeat FSM next state; a low level wins over any pending pulse.
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    rpt_pulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise && REPEAT_EN) begin
          state_d = ST_WAIT;
          rcnt_d  = '0;
        end
      end
      ST_WAIT: begin
        if (rcnt_q == RD_LAST) begin
          state_d   = ST_RPT;
          rcnt_d    = '0;
          rpt_pulse = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      ST_RPT: begin
        if (rcnt_q == RR_LAST) begin
          rcnt_d    = '0;
          rpt_pulse = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!level) begin
      state_d   = ST_IDLE;
      rcnt_d    = '0;
      rpt_pulse = 1'b0;
    end
  end

  assign press_req = rise | rpt_pulse;

endmodule

// File: rtl/btn_frontend.sv
// Push-button front end: NUM_BTN conditioned channels, optional
// lowest-index press arbitration, and registered outputs.
module btn_frontend
  import btn_frontend_pkg::*;
#(
  parameter int               NUM_BTN         = NUM_BTN_DEFAULT,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 1024,
  parameter int               REPEAT_DELAY    = 1 << 22,
  parameter int               REPEAT_RATE     = 1 << 20,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK   = NUM_BTN'(REPEAT_MASK_DEFAULT),
  parameter bit               ONE_HOT         = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  btn_frontend_if.slave    bus
);

  logic [NUM_BTN-1:0] sync_w;
  logic [NUM_BTN-1:0] level_w;
  logic [NUM_BTN-1:0] req_w;
  logic [NUM_BTN-1:0] grant;
  logic [NUM_BTN-1:0] level_p1;
  logic [NUM_BTN-1:0] press_p1;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_frontend_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .raw       (bus.btn_raw[i]),
      .la_in     (bus.la_in[i]),
      .la_mask   (bus.la_mask[i]),
      .sync      (sync_w[i]),
      .level     (level_w[i]),
      .press_req (req_w[i])
    );
  end

  // Keep only the lowest-index request when arbitration is enabled;
  // losing requests are simply dropped.
  always_comb begin
    grant = req_w;
    if (ONE_HOT) grant = req_w & (~req_w + 1'b1);
  end

  // Output stage: levels are passed through unarbitrated.
  always_ff @(posedge clk) begin
    if (!rst) begin
      level_p1 <= '0;
      press_p1 <= '0;
    end else begin
      level_p1 <= level_w;
      press_p1 <= grant;
    end
  end

  assign bus.btn_level = level_p1;
  assign bus.btn_press = press_p1;
  assign bus.debug_out = {level_p1, sync_w};

endmodule
